// File: rtl/dmq_pkg.sv
// dmq_pkg: sizes, entry layout and bypass tag matcher shared by the dm_issue_queue files
package dmq_pkg;
  localparam int REG_ADDRESS_SIZE = 5;
  localparam int REG_SIZE = 32;
  localparam int ID_SIZE = 4;
  localparam int DEPTH = 4;
  localparam int NUM_BYPASS = 2;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int BP_W = NUM_BYPASS > 1 ? $clog2(NUM_BYPASS) : 1;
  typedef logic [ID_SIZE-1:0] tag_t;
  typedef struct packed {
    logic ready;
    tag_t tag;
    logic [REG_SIZE-1:0] value;
  } src_t;
  typedef struct packed {
    logic valid;
    logic op;
    logic [REG_ADDRESS_SIZE-1:0] dest;
    logic w;
    logic use_alu;
    logic use_mul;
    tag_t tag;
    src_t [1:0] src;
  } dmq_entry_t;
  typedef struct packed {
    logic hit;
    logic [BP_W-1:0] index;
  } bp_hit_t;
  // scanning from the top down leaves the lowest matching bus as the winner
  function automatic bp_hit_t bp_match(input tag_t tag, input logic [NUM_BYPASS-1:0] bp_valid,
                                       input logic [NUM_BYPASS*ID_SIZE-1:0] bp_tag);
    bp_hit_t r;
    r = '0;
    for (int i = NUM_BYPASS - 1; i >= 0; i--)
      if (bp_valid[i] && bp_tag[i*ID_SIZE +: ID_SIZE] == tag) r = '{hit: 1'b1, index: BP_W'(i)};
    return r;
  endfunction
endpackage

// File: rtl/dm_issue_queue_if.sv
// dm_issue_queue_if: decode-side, bypass and ALU/MUL issue signals of dm_issue_queue
interface dm_issue_queue_if import dmq_pkg::*; ();
  logic in_valid, in_ready, in_op, in_w, in_use_alu, in_use_mul;
  logic [REG_ADDRESS_SIZE-1:0] in_dest;
  logic in_src1_ready, in_src2_ready;
  tag_t in_src1_tag, in_src2_tag, in_tag;
  logic [REG_SIZE-1:0] in_src1_value, in_src2_value;
  logic rob_stall, flush;
  logic [NUM_BYPASS-1:0] bp_valid;
  logic [NUM_BYPASS*ID_SIZE-1:0] bp_tag;
  logic [NUM_BYPASS*REG_SIZE-1:0] bp_value;
  logic alu_valid, alu_ready, alu_op, alu_w;
  logic [REG_SIZE-1:0] alu_op1, alu_op2;
  logic [REG_ADDRESS_SIZE-1:0] alu_dest;
  tag_t alu_tag;
  logic mul_valid, mul_ready, mul_w;
  logic [REG_SIZE-1:0] mul_op1, mul_op2;
  logic [REG_ADDRESS_SIZE-1:0] mul_dest;
  tag_t mul_tag;
  logic [CNT_W-1:0] count;
  modport slave(
    input in_valid, in_op, in_w, in_use_alu, in_use_mul, in_dest, in_src1_ready, in_src2_ready,
    input in_src1_tag, in_src2_tag, in_src1_value, in_src2_value, rob_stall, flush,
    input bp_valid, bp_tag, bp_value, alu_ready, mul_ready,
    output in_ready, in_tag, count, alu_valid, alu_op, alu_w, alu_op1, alu_op2, alu_dest, alu_tag,
    output mul_valid, mul_w, mul_op1, mul_op2, mul_dest, mul_tag
  );
  modport master(
    output in_valid, in_op, in_w, in_use_alu, in_use_mul, in_dest, in_src1_ready, in_src2_ready,
    output in_src1_tag, in_src2_tag, in_src1_value, in_src2_value, rob_stall, flush,
    output bp_valid, bp_tag, bp_value, alu_ready, mul_ready,
    input in_ready, in_tag, count, alu_valid, alu_op, alu_w, alu_op1, alu_op2, alu_dest, alu_tag,
    input mul_valid, mul_w, mul_op1, mul_op2, mul_dest, mul_tag
  );
endinterface

// File: rtl/dmq_wakeup.sv
// dmq_wakeup: wakes one waiting operand from the lowest-index bypass bus carrying its tag
module dmq_wakeup import dmq_pkg::*; (
  input  src_t                           src_i,
  input  logic [NUM_BYPASS-1:0]          bp_valid,
  input  logic [NUM_BYPASS*ID_SIZE-1:0]  bp_tag,
  input  logic [NUM_BYPASS*REG_SIZE-1:0] bp_value,
  output src_t                           src_o
);
  bp_hit_t m;
  always_comb begin
    m = bp_match(src_i.tag, bp_valid, bp_tag);
    src_o = src_i;
    src_o.ready = src_i.ready || m.hit;
    src_o.value = src_i.ready || !m.hit ? src_i.value : bp_value[m.index*REG_SIZE +: REG_SIZE];
  end
endmodule

// File: rtl/dm_issue_queue.sv
// dm_issue_queue: age-ordered issue queue, bypass wakeup, one ALU + one MUL issue per cycle; DMQ_OUT_OF_ORDER_EN lets ready ops pass stalled older ones
module dm_issue_queue import dmq_pkg::*; (
  input logic clk,
  input logic reset,
  dm_issue_queue_if.slave q
);
`ifdef DMQ_OUT_OF_ORDER_EN
  localparam bit OOO = 1'b1;
`else
  localparam bit OOO = 1'b0;
`endif
  dmq_entry_t ent_q [DEPTH];
  dmq_entry_t ent_d [DEPTH];
  src_t woke [DEPTH][2];
  dmq_entry_t new_e;
  tag_t tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d, k;
  logic [DEPTH-1:0] rdy, alu_c, mul_c;
  logic [IDX_W-1:0] alu_idx, mul_idx;
  logic accept, alu_fire, mul_fire;
  bp_hit_t m1, m2;
  for (genvar i = 0; i < DEPTH; i++) begin : g_e
    for (genvar j = 0; j < 2; j++) begin : g_s
      dmq_wakeup u_wake (
        .src_i(ent_q[i].src[j]),
        .bp_valid(q.bp_valid),
        .bp_tag(q.bp_tag),
        .bp_value(q.bp_value),
        .src_o(woke[i][j])
      );
    end
  end
  assign q.in_ready = !reset && count_q != CNT_W'(DEPTH) && !q.rob_stall && !q.flush;
  assign q.in_tag = tail_q;
  assign q.count = count_q;
  assign accept = q.in_valid && q.in_ready;
  // in-order mode nominates the oldest entry of each class whether or not it is ready
  always_comb begin
    rdy = '0;
    alu_c = '0;
    mul_c = '0;
    alu_idx = '0;
    mul_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rdy[i] = ent_q[i].src[0].ready && ent_q[i].src[1].ready;
      alu_c[i] = ent_q[i].valid && ent_q[i].use_alu && (rdy[i] || !OOO);
      mul_c[i] = ent_q[i].valid && ent_q[i].use_mul && (rdy[i] || !OOO);
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      alu_idx = alu_c[i] ? IDX_W'(i) : alu_idx;
      mul_idx = mul_c[i] ? IDX_W'(i) : mul_idx;
    end
  end
  assign q.alu_valid = !reset && !q.flush && |alu_c && rdy[alu_idx];
  assign q.mul_valid = !reset && !q.flush && |mul_c && rdy[mul_idx];
  assign alu_fire = q.alu_valid && q.alu_ready;
  assign mul_fire = q.mul_valid && q.mul_ready;
  assign q.alu_op1 = ent_q[alu_idx].src[0].value;
  assign q.alu_op2 = ent_q[alu_idx].src[1].value;
  assign q.alu_op = ent_q[alu_idx].op;
  assign q.alu_dest = ent_q[alu_idx].dest;
  assign q.alu_w = ent_q[alu_idx].w;
  assign q.alu_tag = ent_q[alu_idx].tag;
  assign q.mul_op1 = ent_q[mul_idx].src[0].value;
  assign q.mul_op2 = ent_q[mul_idx].src[1].value;
  assign q.mul_dest = ent_q[mul_idx].dest;
  assign q.mul_w = ent_q[mul_idx].w;
  assign q.mul_tag = ent_q[mul_idx].tag;
  // survivors shift down to keep entry 0 oldest; the new op lands right after them
  always_comb begin
    m1 = bp_match(q.in_src1_tag, q.bp_valid, q.bp_tag);
    m2 = bp_match(q.in_src2_tag, q.bp_valid, q.bp_tag);
    new_e = '{valid: 1'b1, op: q.in_op, dest: q.in_dest, w: q.in_w, use_alu: q.in_use_alu,
              use_mul: q.in_use_mul, tag: tail_q, src: '0};
    new_e.src[0] = '{ready: q.in_src1_ready || m1.hit, tag: q.in_src1_tag,
                     value: q.in_src1_ready ? q.in_src1_value : q.bp_value[m1.index*REG_SIZE +: REG_SIZE]};
    new_e.src[1] = '{ready: q.in_src2_ready || m2.hit, tag: q.in_src2_tag,
                     value: q.in_src2_ready ? q.in_src2_value : q.bp_value[m2.index*REG_SIZE +: REG_SIZE]};
    ent_d = '{default: '0};
    k = '0;
    for (int i = 0; i < DEPTH; i++)
      if (ent_q[i].valid && !(alu_fire && alu_idx == IDX_W'(i)) && !(mul_fire && mul_idx == IDX_W'(i))) begin
        ent_d[k[IDX_W-1:0]] = ent_q[i];
        ent_d[k[IDX_W-1:0]].src[0] = woke[i][0];
        ent_d[k[IDX_W-1:0]].src[1] = woke[i][1];
        k = k + CNT_W'(1);
      end
    if (accept) ent_d[k[IDX_W-1:0]] = new_e;
    count_d = q.flush ? '0 : k + CNT_W'(accept);
    tail_d = tail_q + ID_SIZE'(accept);
    if (q.flush) ent_d = '{default: '0};
  end
  always_ff @(posedge clk)
    if (reset) begin
      ent_q <= '{default: '0};
      tail_q <= '0;
      count_q <= '0;
    end else begin
      ent_q <= ent_d;
      tail_q <= tail_d;
      count_q <= count_d;
    end
endmodule

// File: tb/tb_dm_issue_queue.sv
// tb_dm_issue_queue: directed scenarios for dm_issue_queue with hand-computed expectations
module tb_dm_issue_queue;
  import dmq_pkg::*;
`ifdef DMQ_OUT_OF_ORDER_EN
  localparam bit OOO = 1'b1;
`else
  localparam bit OOO = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  dm_issue_queue_if bus();
  dm_issue_queue dut (.clk(clk), .reset(reset), .q(bus));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.bp_valid = '0;
    bus.flush = 1'b0;
  endtask

  task automatic push(input logic alu, input logic r1, input tag_t t1, input logic [31:0] v1, input logic [31:0] v2);
    bus.in_valid = 1'b1;
    bus.in_use_alu = alu;
    bus.in_use_mul = !alu;
    bus.in_op = alu;
    bus.in_w = 1'b1;
    bus.in_dest = v1[4:0];
    bus.in_src1_ready = r1;
    bus.in_src1_tag = t1;
    bus.in_src1_value = v1;
    bus.in_src2_ready = 1'b1;
    bus.in_src2_tag = '0;
    bus.in_src2_value = v2;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    push(1'b1, 1'b1, '0, 32'h0, 32'h0);
    idle();
    bus.rob_stall = 1'b0;
    bus.alu_ready = 1'b1;
    bus.mul_ready = 1'b1;
    bus.bp_tag = '0;
    bus.bp_value = '0;
    step();
    step();
    n_chk++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
    n_chk++; if (bus.alu_valid !== 1'b0) begin n_fail++; $display("FAIL rst_alu_valid: got %b want 0", bus.alu_valid); end
    reset = 1'b0;
    #1;
    n_chk++; if (bus.count !== 3'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", bus.count); end
    n_chk++; if (bus.in_tag !== 4'd0) begin n_fail++; $display("FAIL rst_in_tag: got %0d want 0", bus.in_tag); end
    n_chk++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready_after: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_back_to_back();
    push(1'b1, 1'b1, '0, 32'h1, 32'h2); #1;
    n_chk++; if (bus.in_tag !== 4'd0) begin n_fail++; $display("FAIL b2b_tag0: got %0d want 0", bus.in_tag); end
    step();
    push(1'b1, 1'b1, '0, 32'h3, 32'h4); #1;
    n_chk++; if (bus.in_tag !== 4'd1) begin n_fail++; $display("FAIL b2b_tag1: got %0d want 1", bus.in_tag); end
    n_chk++; if (bus.alu_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid0: got %b want 1", bus.alu_valid); end
    n_chk++; if ({bus.alu_op1, bus.alu_op2} !== {32'h1, 32'h2}) begin n_fail++; $display("FAIL b2b_ops0: got %h/%h want 1/2", bus.alu_op1, bus.alu_op2); end
    n_chk++; if (bus.alu_tag !== 4'd0) begin n_fail++; $display("FAIL b2b_atag0: got %0d want 0", bus.alu_tag); end
    step();
    push(1'b1, 1'b1, '0, 32'h5, 32'h6); #1;
    n_chk++; if (bus.in_tag !== 4'd2) begin n_fail++; $display("FAIL b2b_tag2: got %0d want 2", bus.in_tag); end
    n_chk++; if ({bus.alu_valid, bus.alu_op1, bus.alu_tag} !== {1'b1, 32'h3, 4'd1}) begin n_fail++; $display("FAIL b2b_issue1: got %b/%h/%0d want 1/3/1", bus.alu_valid, bus.alu_op1, bus.alu_tag); end
    step();
    idle(); #1;
    n_chk++; if ({bus.alu_valid, bus.alu_op1, bus.alu_tag} !== {1'b1, 32'h5, 4'd2}) begin n_fail++; $display("FAIL b2b_issue2: got %b/%h/%0d want 1/5/2", bus.alu_valid, bus.alu_op1, bus.alu_tag); end
    n_chk++; if (bus.count !== 3'd1) begin n_fail++; $display("FAIL b2b_count: got %0d want 1", bus.count); end
    step(); #1;
    n_chk++; if ({bus.alu_valid, bus.count} !== {1'b0, 3'd0}) begin n_fail++; $display("FAIL b2b_empty: got %b/%0d want 0/0", bus.alu_valid, bus.count); end
  endtask

  task automatic test_wakeup();
    push(1'b1, 1'b0, 4'd5, 32'h0, 32'h7); #1;
    n_chk++; if (bus.in_tag !== 4'd3) begin n_fail++; $display("FAIL wk_tag: got %0d want 3", bus.in_tag); end
    step();
    idle(); #1;
    n_chk++; if ({bus.alu_valid, bus.count} !== {1'b0, 3'd1}) begin n_fail++; $display("FAIL wk_waiting: got %b/%0d want 0/1", bus.alu_valid, bus.count); end
    step();
    bus.bp_valid = 2'b10;
    bus.bp_tag = {4'd5, 4'd0};
    bus.bp_value = {32'hDEAD, 32'h0};
    #1;
    n_chk++; if (bus.alu_valid !== 1'b0) begin n_fail++; $display("FAIL wk_not_yet: got %b want 0", bus.alu_valid); end
    step();
    idle(); #1;
    n_chk++; if ({bus.alu_valid, bus.alu_op1, bus.alu_op2, bus.alu_tag} !== {1'b1, 32'hDEAD, 32'h7, 4'd3}) begin n_fail++; $display("FAIL wk_issue: got %b/%h/%h/%0d want 1/dead/7/3", bus.alu_valid, bus.alu_op1, bus.alu_op2, bus.alu_tag); end
    step(); #1;
    n_chk++; if (bus.count !== 3'd0) begin n_fail++; $display("FAIL wk_drained: got %0d want 0", bus.count); end
  endtask

  task automatic test_capture();
    push(1'b1, 1'b0, 4'd9, 32'h0, 32'h8);
    bus.bp_valid = 2'b11;
    bus.bp_tag = {4'd9, 4'd9};
    bus.bp_value = {32'h22, 32'h11};
    step();
    idle(); #1;
    n_chk++; if ({bus.alu_valid, bus.alu_op1, bus.alu_tag} !== {1'b1, 32'h11, 4'd4}) begin n_fail++; $display("FAIL cap_issue: got %b/%h/%0d want 1/11/4", bus.alu_valid, bus.alu_op1, bus.alu_tag); end
    step();
  endtask

  task automatic test_full();
    bus.mul_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(1'b0, 1'b1, '0, 32'h10 + i, 32'h0);
      step();
    end
    push(1'b0, 1'b1, '0, 32'h99, 32'h0); #1;
    n_chk++; if ({bus.count, bus.in_ready} !== {3'd4, 1'b0}) begin n_fail++; $display("FAIL full_state: got %0d/%b want 4/0", bus.count, bus.in_ready); end
    n_chk++; if ({bus.mul_valid, bus.mul_op1, bus.in_tag} !== {1'b1, 32'h10, 4'd9}) begin n_fail++; $display("FAIL full_head: got %b/%h/%0d want 1/10/9", bus.mul_valid, bus.mul_op1, bus.in_tag); end
    step();
    bus.mul_ready = 1'b1; #1;
    n_chk++; if ({bus.count, bus.in_ready} !== {3'd4, 1'b0}) begin n_fail++; $display("FAIL full_no_accept: got %0d/%b want 4/0", bus.count, bus.in_ready); end
    step();
    idle(); #1;
    n_chk++; if ({bus.count, bus.in_ready, bus.mul_op1, bus.mul_tag, bus.in_tag} !== {3'd3, 1'b1, 32'h11, 4'd6, 4'd9}) begin n_fail++; $display("FAIL full_drain1: got %0d/%b/%h/%0d/%0d want 3/1/11/6/9", bus.count, bus.in_ready, bus.mul_op1, bus.mul_tag, bus.in_tag); end
    step(); #1;
    n_chk++; if ({bus.count, bus.mul_op1} !== {3'd2, 32'h12}) begin n_fail++; $display("FAIL full_drain2: got %0d/%h want 2/12", bus.count, bus.mul_op1); end
    step(); #1;
    n_chk++; if ({bus.count, bus.mul_op1} !== {3'd1, 32'h13}) begin n_fail++; $display("FAIL full_drain3: got %0d/%h want 1/13", bus.count, bus.mul_op1); end
    step(); #1;
    n_chk++; if ({bus.count, bus.mul_valid} !== {3'd0, 1'b0}) begin n_fail++; $display("FAIL full_empty: got %0d/%b want 0/0", bus.count, bus.mul_valid); end
  endtask

  task automatic test_out_of_order();
    push(1'b1, 1'b0, 4'd12, 32'h0, 32'h0); #1;
    n_chk++; if (bus.in_tag !== 4'd9) begin n_fail++; $display("FAIL ooo_tag: got %0d want 9", bus.in_tag); end
    step();
    push(1'b1, 1'b1, '0, 32'hB, 32'h0); #1;
    n_chk++; if (bus.alu_valid !== 1'b0) begin n_fail++; $display("FAIL ooo_blocked: got %b want 0", bus.alu_valid); end
    step();
    idle();
    bus.bp_valid = 2'b01;
    bus.bp_tag = {4'd0, 4'd12};
    bus.bp_value = {32'h0, 32'hA};
    #1;
    n_chk++; if ({bus.alu_valid, bus.alu_tag} !== {OOO, OOO ? 4'd10 : 4'd9}) begin n_fail++; $display("FAIL ooo_young: got %b/%0d want %b/%0d", bus.alu_valid, bus.alu_tag, OOO, OOO ? 10 : 9); end
    step();
    idle(); #1;
    n_chk++; if ({bus.alu_valid, bus.alu_op1, bus.alu_tag} !== {1'b1, 32'hA, 4'd9}) begin n_fail++; $display("FAIL ooo_old: got %b/%h/%0d want 1/a/9", bus.alu_valid, bus.alu_op1, bus.alu_tag); end
    step(); #1;
    n_chk++; if ({bus.alu_valid, bus.count} !== {!OOO, OOO ? 3'd0 : 3'd1}) begin n_fail++; $display("FAIL ooo_tail: got %b/%0d want %b/%0d", bus.alu_valid, bus.count, !OOO, OOO ? 0 : 1); end
    step(); #1;
    n_chk++; if (bus.count !== 3'd0) begin n_fail++; $display("FAIL ooo_empty: got %0d want 0", bus.count); end
  endtask

  task automatic test_flush();
    bus.alu_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push(1'b1, 1'b1, '0, 32'h40 + i, 32'h0);
      step();
    end
    push(1'b1, 1'b1, '0, 32'h50, 32'h0);
    bus.flush = 1'b1;
    bus.alu_ready = 1'b1;
    #1;
    n_chk++; if ({bus.count, bus.alu_valid, bus.in_ready, bus.in_tag} !== {3'd3, 1'b0, 1'b0, 4'd14}) begin n_fail++; $display("FAIL fl_during: got %0d/%b/%b/%0d want 3/0/0/14", bus.count, bus.alu_valid, bus.in_ready, bus.in_tag); end
    step();
    idle(); #1;
    n_chk++; if ({bus.count, bus.alu_valid, bus.in_tag} !== {3'd0, 1'b0, 4'd14}) begin n_fail++; $display("FAIL fl_after: got %0d/%b/%0d want 0/0/14", bus.count, bus.alu_valid, bus.in_tag); end
    push(1'b1, 1'b1, '0, 32'h60, 32'h0);
    step();
    idle(); #1;
    n_chk++; if ({bus.alu_valid, bus.alu_op1, bus.alu_tag} !== {1'b1, 32'h60, 4'd14}) begin n_fail++; $display("FAIL fl_reuse: got %b/%h/%0d want 1/60/14", bus.alu_valid, bus.alu_op1, bus.alu_tag); end
    step();
  endtask

  task automatic test_wrap_dual();
    bus.alu_ready = 1'b0;
    bus.mul_ready = 1'b0;
    push(1'b0, 1'b1, '0, 32'h21, 32'h0); #1;
    n_chk++; if (bus.in_tag !== 4'd15) begin n_fail++; $display("FAIL wrap_15: got %0d want 15", bus.in_tag); end
    step();
    push(1'b1, 1'b1, '0, 32'h31, 32'h0); #1;
    n_chk++; if (bus.in_tag !== 4'd0) begin n_fail++; $display("FAIL wrap_0: got %0d want 0", bus.in_tag); end
    step();
    idle(); #1;
    n_chk++; if ({bus.count, bus.alu_valid, bus.mul_valid, bus.mul_tag, bus.alu_tag} !== {3'd2, 1'b1, 1'b1, 4'd15, 4'd0}) begin n_fail++; $display("FAIL dual_ready: got %0d/%b/%b/%0d/%0d want 2/1/1/15/0", bus.count, bus.alu_valid, bus.mul_valid, bus.mul_tag, bus.alu_tag); end
    bus.alu_ready = 1'b1;
    bus.mul_ready = 1'b1;
    step(); #1;
    n_chk++; if ({bus.count, bus.in_tag} !== {3'd0, 4'd1}) begin n_fail++; $display("FAIL dual_issue: got %0d/%0d want 0/1", bus.count, bus.in_tag); end
  endtask

  task automatic test_reset_mid();
    bus.alu_ready = 1'b0;
    push(1'b1, 1'b1, '0, 32'h70, 32'h0);
    step();
    reset = 1'b1;
    bus.alu_ready = 1'b1;
    #1;
    n_chk++; if ({bus.alu_valid, bus.in_ready} !== 2'b00) begin n_fail++; $display("FAIL rmid_during: got %b/%b want 0/0", bus.alu_valid, bus.in_ready); end
    step();
    reset = 1'b0;
    idle(); #1;
    n_chk++; if ({bus.count, bus.in_tag, bus.alu_valid} !== {3'd0, 4'd0, 1'b0}) begin n_fail++; $display("FAIL rmid_after: got %0d/%0d/%b want 0/0/0", bus.count, bus.in_tag, bus.alu_valid); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_wakeup();
    test_capture();
    test_full();
    test_out_of_order();
    test_flush();
    test_wrap_dual();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
